// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants, types and helpers for the seven-segment display blocks
// Purpose: active-low segment patterns for hex digits 0-F, all-off constants for
//          anode/segment pins, the register-set struct and the slot-length helper.
// Ports:   none (package).
package seg7_pkg;

  localparam logic [7:0] ANODE_OFF = 8'hFF;
  localparam logic [6:0] SEG_OFF   = 7'h7F;

  // Segment order {g,f,e,d,c,b,a}, 0 = segment lit.
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  // One complete display word: eight nibbles plus per-digit dp and enable masks.
  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  en;
  } disp_word_t;

  // Clock cycles per digit slot, never less than one even for silly rate settings.
  function automatic int unsigned digit_cycles(input int unsigned clk_freq,
                                               input int unsigned scan_hz);
    int unsigned q;
    q = (scan_hz == 0) ? 1 : clk_freq / scan_hz;
    return (q < 1) ? 1 : q;
  endfunction

endpackage

// File: rtl/seg7_scan_if.sv
// rtl/seg7_scan_if.sv - word-load bus between the display datapath and the scanner
// Purpose: carries the one-cycle load strobe with its word/masks and returns the
//          pending flag.
// Signals: load (strobe), data_in[31:0], dp_in[7:0], en_in[7:0], pending.
// Modports: master = word producer, slave = seg7_scan.
interface seg7_scan_if;
  logic        load;
  logic [31:0] data_in;
  logic [7:0]  dp_in;
  logic [7:0]  en_in;
  logic        pending;

  modport master (output load, output data_in, output dp_in, output en_in, input pending);
  modport slave  (input load, input data_in, input dp_in, input en_in, output pending);
endinterface

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational hex nibble to active-low seven-segment decoder
// Purpose: maps 0-F onto segment patterns {g,f,e,d,c,b,a}, 0 = lit.
// Ports:   nibble[3:0] in, seg[6:0] out.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - time-multiplexed driver for an 8-digit common-anode display
// Purpose: scans digits 0..7 one slot at a time, blanking the start of every slot,
//          and swaps in newly loaded words only when digit 7 wraps to digit 0.
// Ports:   clk, rst_n (async, active low); ld (seg7_scan_if.slave: load, data_in,
//          dp_in, en_in, pending); anode[7:0], cathode[6:0], dp (all active low);
//          frame_start (one-cycle pulse on digit 0's first output cycle).
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 100_000_000,
  parameter int unsigned SCAN_HZ      = 1000,
  parameter int unsigned BLANK_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  seg7_scan_if.slave       ld,
  output logic [7:0]       anode,
  output logic [6:0]       cathode,
  output logic             dp,
  output logic             frame_start
);

  localparam int unsigned DIGIT_CYCLES = digit_cycles(CLK_FREQ, SCAN_HZ);
  localparam int unsigned CW           = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CW-1:0] SLOT_LAST  = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_SLOT = CW'(BLANK_CYCLES);

  logic [CW-1:0] slot_q, slot_d;
  logic [2:0]    digit_q, digit_d;
  disp_word_t    pend_q, pend_d;
  logic          pend_valid_q, pend_valid_d;
  disp_word_t    disp_q, disp_d;
  logic [7:0]    anode_q, anode_d;
  logic [6:0]    cathode_q, cathode_d;
  logic          dp_q, dp_d;
  logic          frame_start_q, frame_start_d;

  disp_word_t    in_word;
  logic          wrap;
  logic [3:0]    nibble;
  logic [6:0]    seg_dec;

  assign in_word = '{data: ld.data_in, dp: ld.dp_in, en: ld.en_in};
  assign wrap    = (slot_q == SLOT_LAST) && (digit_q == 3'd7);
  assign nibble  = disp_q.data[{digit_q, 2'b00} +: 4];

  seg7_decode u_decode (
    .nibble (nibble),
    .seg    (seg_dec)
  );

  // Scan counters and the two register sets.
  always_comb begin
    slot_d       = slot_q;
    digit_d      = digit_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    disp_d       = disp_q;

    if (slot_q == SLOT_LAST) begin
      slot_d  = '0;
      digit_d = digit_q + 3'd1;
    end else begin
      slot_d = slot_q + CW'(1);
    end

    if (wrap) begin
      // A load arriving on the wrap cycle is newer than anything pending,
      // so it goes straight to the display set.
      if (ld.load) begin
        disp_d       = in_word;
        pend_d       = in_word;
        pend_valid_d = 1'b0;
      end else if (pend_valid_q) begin
        disp_d       = pend_q;
        pend_valid_d = 1'b0;
      end
    end else if (ld.load) begin
      pend_d       = in_word;
      pend_valid_d = 1'b1;
    end
  end

  // Pin values for the current counter state, registered one cycle later.
  always_comb begin
    anode_d       = ANODE_OFF;
    cathode_d     = SEG_OFF;
    dp_d          = 1'b1;
    frame_start_d = (slot_q == '0) && (digit_q == 3'd0);
    if ((slot_q >= BLANK_SLOT) && disp_q.en[digit_q]) begin
      anode_d   = ~(8'd1 << digit_q);
      cathode_d = seg_dec;
      dp_d      = ~disp_q.dp[digit_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q        <= '0;
      digit_q       <= 3'd0;
      pend_q        <= '0;
      pend_valid_q  <= 1'b0;
      disp_q        <= '0;
      anode_q       <= ANODE_OFF;
      cathode_q     <= SEG_OFF;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      slot_q        <= slot_d;
      digit_q       <= digit_d;
      pend_q        <= pend_d;
      pend_valid_q  <= pend_valid_d;
      disp_q        <= disp_d;
      anode_q       <= anode_d;
      cathode_q     <= cathode_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign anode       = anode_q;
  assign cathode     = cathode_q;
  assign dp          = dp_q;
  assign frame_start = frame_start_q;
  assign ld.pending  = pend_valid_q;

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Time-multiplexed driver for the board's 8-digit common-anode seven-segment display. It sits directly downstream of the ROM/display datapath: it accepts a 32-bit hex word (8 nibbles) plus per-digit decimal-point and enable masks through a one-cycle load strobe. It scans one digit at a time at a parameterised rate. New words are committed only at frame boundaries, so a displayed frame never mixes two words.

## Interface
- CLK_FREQ, 100_000_000 — clock frequency in Hz (benches use 400)
- SCAN_HZ, 1000 — per-digit slot rate in Hz; DIGIT_CYCLES = max(1, CLK_FREQ/SCAN_HZ)
- BLANK_CYCLES, 1 — all-anodes-off guard at the start of each slot; must be < DIGIT_CYCLES

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- load  in  1  one-cycle strobe; capture data_in/dp_in/en_in
- data_in  in  32  nibble k (bits 4k+3:4k) shown on digit k
- dp_in  in  8  decimal point per digit, 1 = lit
- en_in  in  8  digit enable, 0 = digit stays dark
- anode  out  8  active-low digit select
- cathode  out  7  active-low segments, order {g,f,e,d,c,b,a}
- dp  out  1  active-low decimal point
- pending  out  1  a loaded word is waiting for the frame boundary
- frame_start  out  1  one-cycle pulse when digit 0's slot begins

## Operation
- Slot counter counts 0..DIGIT_CYCLES-1. At terminal count it clears, and the digit index advances 0→1→…→7→0 (wrap).
- Two register sets:
  - pending set: data, dp, en, pending flag
  - display set: data, dp, en
- load=1: the pending set captures the inputs and the pending flag is set.
  - A second load before commit overwrites it; the latest word wins.
- Commit happens on the cycle the digit index wraps 7→0.
  - If pending=1: the display set takes the pending set, and pending clears.
  - If load coincides with the wrap cycle: the input word commits directly to the display set, and pending stays/clears to 0.
- Slot output for digit k:
  - Slot counter < BLANK_CYCLES: anode=8'hFF, cathode=7'h7F, dp=1.
  - Otherwise: anode = ~(1<<k) if en[k]=1, else 8'hFF.
  - Otherwise: cathode = decode(nibble k) and dp = ~dp[k].
  - When en[k]=0, cathode=7'h7F and dp=1.
- Decode (active-low):
  - 0→1000000, 1→1111001, 2→0100100, 3→0110000
  - 4→0011001, 5→0010010, 6→0000010, 7→1111000
  - 8→0000000, 9→0010000, A→0001000, b→0000011
  - C→1000110, d→0100001, E→0000110, F→0001110
- Reset (asynchronous, any time including mid-frame):
  - anode=8'hFF, cathode=7'h7F, dp=1, pending=0, frame_start=0
  - Counters, digit index and both register sets cleared to 0
  - Scanning restarts at digit 0, slot cycle 0.

## Timing
- All outputs are registered, with one cycle of latency from the counter state to the pins.
- Frame length = 8·DIGIT_CYCLES cycles; the anode for digit k is low for DIGIT_CYCLES-BLANK_CYCLES cycles per frame.
- frame_start is high exactly one cycle, aligned with the first (blanked) output cycle of digit 0.
- Load at cycle t → pending=1 at t+1.
  - The new word appears starting at the digit-0 slot after the next 7→0 wrap.
  - Worst-case load-to-display is 8·DIGIT_CYCLES+1 cycles.
- First frame_start after reset release: cycle 1. No pulse is generated while rst_n=0.

## Structure
- Package seg7_pkg holds:
  - the SEG_* active-low patterns for 0–F
  - constants ANODE_OFF=8'hFF and SEG_OFF=7'h7F
  - a helper computing DIGIT_CYCLES with the minimum-1 clamp
- Sub-module seg7_decode: combinational 4-bit → 7-bit active-low decoder. It is shared with any future display blocks.

## Test plan
Bench parameters: CLK_FREQ=400, SCAN_HZ=100 (DIGIT_CYCLES=4), BLANK_CYCLES=1, frame = 32 cycles.

- **Reset:** hold rst_n=0 for 20 ns, then check anode=FF, cathode=7F, dp=1, pending=0. Release; frame_start pulses at cycle 1, then every 32 cycles.
- **Scan order:** load 32'h76543210, en=FF, dp=00, and wait one frame. Each slot shows 1 blank cycle then 3 active cycles. Anode sequence is FE,FD,…,7F with cathodes 1000000,1111001,…,1111000.
- **Frame-atomic update:** load 32'h89ABCDEF mid-frame (digit 3). pending=1 until the wrap; the current frame stays 76543210, the next frame shows F,E,d,C,b,A,9,8.
- **Load collisions:**
  - Two loads (11111111 then 22222222) within one frame → only 2s are ever shown.
  - A load on the 7→0 wrap cycle → displayed in the immediately following digit-0 slot, with pending=0.
- **Masks:** en=8'h0F, dp=8'h01. Digits 4–7 are never selected (anode bits 7:4 stay 1); dp=0 only during digit 0's active cycles.
- **Reset mid-frame:** assert rst_n low during the digit-5 slot. Outputs go to reset values asynchronously and the display set returns to 0; after release, scanning restarts at digit 0 showing "0".
